// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S 16-bit control path: decoded instruction set, controller
// states, ALU operation codes and the conditional-branch rule.
package k_and_s_pkg;

   typedef enum logic [4:0] {
      I_NOP    = 5'd0,
      I_LOAD   = 5'd1,
      I_STORE  = 5'd2,
      I_MOVE   = 5'd3,
      I_ADD    = 5'd4,
      I_SUB    = 5'd5,
      I_AND    = 5'd6,
      I_OR     = 5'd7,
      I_BRANCH = 5'd8,
      I_BZERO  = 5'd9,
      I_BNZERO = 5'd10,
      I_BNEG   = 5'd11,
      I_BNNEG  = 5'd12,
      I_BOV    = 5'd13,
      I_BNOV   = 5'd14,
      I_HALT   = 5'd15
   } decoded_instruction_type;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } ctrl_state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_AND = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;
   localparam logic [1:0] ALU_SUB = 2'b11;

   // Non-branch instructions report "not taken".
   function automatic logic branch_taken(input decoded_instruction_type instr,
                                         input logic z,
                                         input logic n,
                                         input logic sov);
      logic taken;
      taken = 1'b0;
      case (instr)
         I_BRANCH: taken = 1'b1;
         I_BZERO:  taken = z;
         I_BNZERO: taken = ~z;
         I_BNEG:   taken = n;
         I_BNNEG:  taken = ~n;
         I_BOV:    taken = sov;
         I_BNOV:   taken = ~sov;
         default:  taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the K&S datapath; 3 cycles per instruction,
// no backpressure. Outputs are decoded combinationally from the state register.
module control_unit
   import k_and_s_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halt,
   output logic [CNT_W-1:0]        retired_count
);

   ctrl_state_t state, state_nxt;

   // Carried for debug visibility only; no branch depends on it.
   logic unused_uov;
   assign unused_uov = unsigned_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         retired_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_EXEC)
            retired_count <= retired_count + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt        = state;
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = ALU_ADD;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;

      case (state)
         S_IDLE: state_nxt = S_FETCH;

         S_FETCH: begin
            addr_sel  = 1'b0;
            ir_enable = 1'b1;
            state_nxt = S_DECODE;
         end

         S_DECODE: begin
            pc_enable = 1'b1;
            branch    = 1'b0;
            state_nxt = S_EXEC;
         end

         S_EXEC: begin
            state_nxt = S_FETCH;
            case (decoded_instruction)
               I_LOAD: begin
                  addr_sel         = 1'b1;
                  c_sel            = 1'b1;
                  write_reg_enable = 1'b1;
               end
               I_STORE: begin
                  addr_sel         = 1'b1;
                  ram_write_enable = 1'b1;
               end
               I_MOVE: begin
                  operation        = ALU_OR;
                  write_reg_enable = 1'b1;
               end
               I_ADD: begin
                  operation        = ALU_ADD;
                  write_reg_enable = 1'b1;
                  flags_reg_enable = 1'b1;
               end
               I_SUB: begin
                  operation        = ALU_SUB;
                  write_reg_enable = 1'b1;
                  flags_reg_enable = 1'b1;
               end
               I_AND: begin
                  operation        = ALU_AND;
                  write_reg_enable = 1'b1;
                  flags_reg_enable = 1'b1;
               end
               I_OR: begin
                  operation        = ALU_OR;
                  write_reg_enable = 1'b1;
                  flags_reg_enable = 1'b1;
               end
               I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                  if (branch_taken(decoded_instruction, zero_op, neg_op, signed_overflow)) begin
                     branch    = 1'b1;
                     pc_enable = 1'b1;
                  end
               end
               I_HALT:  state_nxt = S_HALT;
               default: ;
            endcase
         end

         S_HALT: begin
            halt      = 1'b1;
            state_nxt = S_HALT;
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit; expected strobes come from an
// instruction-level table and a modulo retired-instruction counter.
module tb_control_unit;
   import k_and_s_pkg::*;

   localparam int CW = 4;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   decoded_instruction_type decoded_instruction = I_NOP;
   logic                    zero_op = 1'b0;
   logic                    neg_op = 1'b0;
   logic                    unsigned_overflow = 1'b0;
   logic                    signed_overflow = 1'b0;
   logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
   logic [1:0]              operation;
   logic                    write_reg_enable, flags_reg_enable, ram_write_enable, halt;
   logic [CW-1:0]           retired_count;

   control_unit #(.CNT_W(CW)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .decoded_instruction (decoded_instruction),
      .zero_op             (zero_op),
      .neg_op              (neg_op),
      .unsigned_overflow   (unsigned_overflow),
      .signed_overflow     (signed_overflow),
      .branch              (branch),
      .pc_enable           (pc_enable),
      .ir_enable           (ir_enable),
      .addr_sel            (addr_sel),
      .c_sel               (c_sel),
      .operation           (operation),
      .write_reg_enable    (write_reg_enable),
      .flags_reg_enable    (flags_reg_enable),
      .ram_write_enable    (ram_write_enable),
      .halt                (halt),
      .retired_count       (retired_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int model_cnt = 0;

   // {branch, pc_enable, ir_enable, addr_sel, c_sel, operation, wr_reg, flags, ram_we, halt}
   logic [10:0] obs;
   assign obs = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                 write_reg_enable, flags_reg_enable, ram_write_enable, halt};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [10:0] vec(input bit br, input bit pc, input bit ir, input bit as,
                                        input bit cs, input logic [1:0] op, input bit wr,
                                        input bit fl, input bit rw, input bit h);
      return {br, pc, ir, as, cs, op, wr, fl, rw, h};
   endfunction

   // Branch rule as a table: which flag is tested and which polarity takes the branch.
   function automatic bit model_taken(input int ins, input bit z, input bit n, input bit v);
      bit flags[3];
      flags[0] = z; flags[1] = n; flags[2] = v;
      if (ins == 8) return 1'b1;
      if (ins >= 9 && ins <= 14) return flags[(ins - 9) / 2] == (((ins - 9) % 2) == 0);
      return 1'b0;
   endfunction

   function automatic logic [10:0] model_exec(input int ins, input bit z, input bit n, input bit v);
      case (ins)
         1:  return vec(0, 0, 0, 1, 1, 2'b00, 1, 0, 0, 0);  // LOAD
         2:  return vec(0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 0);  // STORE
         3:  return vec(0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0);  // MOVE
         4:  return vec(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0);  // ADD
         5:  return vec(0, 0, 0, 0, 0, 2'b11, 1, 1, 0, 0);  // SUB
         6:  return vec(0, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0);  // AND
         7:  return vec(0, 0, 0, 0, 0, 2'b10, 1, 1, 0, 0);  // OR
         default: begin
            if (model_taken(ins, z, n, v)) return vec(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
            return '0;
         end
      endcase
   endfunction

   task automatic scramble_inputs();
      decoded_instruction = decoded_instruction_type'($urandom_range(0, 31));
      zero_op           = 1'($urandom);
      neg_op            = 1'($urandom);
      unsigned_overflow = 1'($urandom);
      signed_overflow   = 1'($urandom);
   endtask

   // Drives rst_n low for 3 cycles, checks quiet outputs, releases, checks the idle cycle.
   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      model_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         scramble_inputs();
         @(negedge clk);
         check_eq("reset_outputs", 32'(obs), 32'(0));
         check_eq("reset_count", 32'(retired_count), 32'(0));
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      scramble_inputs();
      @(negedge clk);
      check_eq("idle_outputs", 32'(obs), 32'(0));
   endtask

   // One full instruction; on entry the DUT will enter FETCH at the next rising edge.
   task automatic run_instr(input int ins, input bit z, input bit n, input bit v, input bit abort);
      @(posedge clk); #1;
      scramble_inputs();
      @(negedge clk);
      check_eq("fetch_strobes", 32'(obs), 32'(vec(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0)));
      check_eq("fetch_count", 32'(retired_count), 32'(model_cnt));

      @(posedge clk); #1;
      scramble_inputs();
      decoded_instruction = decoded_instruction_type'(ins);
      @(negedge clk);
      check_eq("decode_strobes", 32'(obs), 32'(vec(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0)));

      @(posedge clk); #1;
      zero_op = z; neg_op = n; signed_overflow = v;
      unsigned_overflow = 1'($urandom);
      @(negedge clk);
      check_eq($sformatf("exec_ins%0d_z%0d_n%0d_v%0d", ins, z, n, v), 32'(obs),
               32'(model_exec(ins, z, n, v)));
      check_eq("exec_count", 32'(retired_count), 32'(model_cnt));

      if (abort) begin
         #2 rst_n = 1'b0;
         #1;
         check_eq("abort_ram_we", 32'(ram_write_enable), 32'(0));
         check_eq("abort_outputs", 32'(obs), 32'(0));
         check_eq("abort_count", 32'(retired_count), 32'(0));
         model_cnt = 0;
         return;
      end
      model_cnt = (model_cnt + 1) % (1 << CW);

      if (ins == 15) begin
         for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            scramble_inputs();
            @(negedge clk);
            check_eq("halt_strobes", 32'(obs), 32'(vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1)));
            check_eq("halt_count", 32'(retired_count), 32'(model_cnt));
         end
      end
   endtask

   initial begin
      apply_reset();

      // Directed: ALU, memory, move and NOP.
      run_instr(4, 0, 0, 0, 0);
      run_instr(1, 1, 1, 1, 0);
      run_instr(2, 0, 1, 0, 0);
      run_instr(3, 1, 0, 1, 0);
      run_instr(5, 0, 0, 1, 0);
      run_instr(6, 1, 1, 0, 0);
      run_instr(7, 0, 1, 1, 0);
      run_instr(0, 1, 1, 1, 0);

      // Every branch kind with its tested flag at both polarities, other flags opposite.
      for (int b = 8; b <= 14; b++) begin
         for (int p = 0; p < 2; p++) begin
            bit z, n, v;
            z = (b == 9 || b == 10) ? bit'(p) : bit'(!p);
            n = (b == 11 || b == 12) ? bit'(p) : bit'(!p);
            v = (b == 13 || b == 14) ? bit'(p) : bit'(!p);
            run_instr(b, z, n, v, 0);
         end
      end

      // Random instruction mix including illegal encodings; HALT excluded here.
      for (int k = 0; k < 200; k++) begin
         int ins;
         ins = $urandom_range(0, 31);
         if (ins == 15) ins = 0;
         run_instr(ins, 1'($urandom), 1'($urandom), 1'($urandom), 0);
      end

      // Counter wrap from a clean reset.
      apply_reset();
      for (int k = 0; k < 16; k++) run_instr(0, 0, 0, 0, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("wrap_count", 32'(retired_count), 32'(0));
      check_eq("wrap_fetch", 32'(obs), 32'(vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)) | 32'(vec(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0)));

      // HALT, then reset pulse back to normal operation.
      apply_reset();
      run_instr(4, 0, 0, 0, 0);
      run_instr(15, 0, 0, 0, 0);
      apply_reset();
      run_instr(9, 1, 0, 0, 0);

      // Reset during STORE execute.
      run_instr(2, 0, 0, 0, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_abort_idle", 32'(obs), 32'(0));
      run_instr(4, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
